clken_nco: RTL

CLKEN_NCO -- requirements
Module: clken_nco

---
 rtl/clk_pkg.sv | 33 +++
 rtl/nco_chan.sv | 57 +++++
 rtl/clken_nco.sv | 134 +++++++++++++
 3 files changed

// File: rtl/clk_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clk_pkg
//  Description : Shared limits, types and helpers for the clock-enable NCO
//                block. CH_IDX_W is the width of the channel-select field.
//                calc_inc turns a (reference Hz, output Hz) pair into a phase
//                increment for an accumulator of a given width.
//  Revision    : 1.0  initial release
// ============================================================================
package clk_pkg;

    localparam int MAX_CH   = 8;
    localparam int CH_IDX_W = 3;

    typedef logic [CH_IDX_W-1:0] ch_idx_t;

    // The increment is out_hz * 2^acc_w / ref_hz, truncated toward zero.
    // A zero reference frequency yields 0, which parks the channel.
    function automatic logic [31:0] calc_inc(
        input longint unsigned ref_hz,
        input longint unsigned out_hz,
        input int unsigned     acc_w
    );
        longint unsigned num;
        if (ref_hz == 0) begin
            return 32'd0;
        end
        num = out_hz << acc_w;
        return 32'(num / ref_hz);
    endfunction

endpackage : clk_pkg
`default_nettype wire

// File: rtl/nco_chan.sv
`default_nettype none
// ============================================================================
//  Module      : nco_chan
//  Description : One NCO channel. A phase accumulator advances by i_inc each
//                cycle. The carry out of the add is registered as o_ce. o_sq
//                is the accumulator MSB, delayed by one register.
//  Ports       : clk    - clock
//                rst    - synchronous active-high reset
//                i_inc  - phase increment (held by the parent)
//                i_clr  - load the accumulator with zero instead of adding
//                o_ce   - single-cycle clock-enable pulse
//                o_sq   - square wave output
//  Revision    : 1.0  initial release
// ============================================================================
module nco_chan #(
    parameter int ACC_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ACC_W-1:0] i_inc,
    input  logic             i_clr,
    output logic             o_ce,
    output logic             o_sq
);

    logic [ACC_W-1:0] r_acc;
    logic             r_ce;
    logic             r_sq;
    logic [ACC_W:0]   w_sum;

    // One extra bit captures the carry out of the modulo-2^ACC_W add.
    assign w_sum = {1'b0, r_acc} + {1'b0, i_inc};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
            r_ce  <= 1'b0;
            r_sq  <= 1'b0;
        end else begin
            r_sq <= r_acc[ACC_W-1];
            // A clear overrides the add. It also suppresses any carry that
            // the add would have produced in the same cycle.
            if (i_clr) begin
                r_acc <= '0;
                r_ce  <= 1'b0;
            end else begin
                r_acc <= w_sum[ACC_W-1:0];
                r_ce  <= w_sum[ACC_W];
            end
        end
    end

    assign o_ce = r_ce;
    assign o_sq = r_sq;

endmodule : nco_chan
`default_nettype wire

// File: rtl/clken_nco.sv
`default_nettype none
// ============================================================================
//  Module      : clken_nco
//  Description : Multi-channel clock-enable generator. Each channel is an NCO
//                whose increment is written through a valid/ready
//                configuration port. A lock counter reports when every
//                channel is programmed and has settled.
//  Ports       : refclk        - sole clock
//                rst           - synchronous active-high reset
//                cfg_valid     - configuration write request
//                cfg_ready     - a write can be accepted this cycle
//                cfg_ch        - target channel
//                cfg_inc       - new phase increment
//                cfg_phase_clr - also zero the target accumulator
//                cfg_err       - pulse: last accepted write had a bad channel
//                ce            - per-channel clock-enable pulses
//                sq            - per-channel square waves
//                locked        - all channels nonzero and settled
//  Revision    : 1.0  initial release
// ============================================================================
module clken_nco
    import clk_pkg::*;
#(
    parameter int NUM_CH   = 3,
    parameter int ACC_W    = 32,
    parameter int LOCK_CYC = 16
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  ch_idx_t           cfg_ch,
    input  logic [ACC_W-1:0]  cfg_inc,
    input  logic              cfg_phase_clr,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] ce,
    output logic [NUM_CH-1:0] sq,
    output logic              locked
);

    localparam int                  c_lcw      = $clog2(LOCK_CYC + 1);
    localparam logic [c_lcw-1:0]    c_lock_max = c_lcw'(LOCK_CYC);
    localparam logic [CH_IDX_W:0]   c_num_ch   = (CH_IDX_W + 1)'(NUM_CH);

    logic              r_cfg_ready;
    logic              r_cfg_err;
    logic [c_lcw-1:0]  r_lock_cnt;

    logic              w_accept;
    logic              w_ch_ok;
    logic              w_wr_ok;
    logic              w_wr_bad;
    logic [NUM_CH-1:0] w_inc_nz;
    logic              w_all_nz;

    // ------------------------------------------------------------------
    // Configuration handshake
    // ------------------------------------------------------------------
    assign w_accept = cfg_valid & r_cfg_ready;
    assign w_ch_ok  = ({1'b0, cfg_ch} < c_num_ch);
    assign w_wr_ok  = w_accept & w_ch_ok;
    assign w_wr_bad = w_accept & ~w_ch_ok;

    // Ready drops for the one cycle after each accept, so the write
    // rate is limited to one every other cycle. Ready stays low during
    // reset and returns on the first cycle after reset is released.
    always_ff @(posedge refclk) begin
        if (rst) begin
            r_cfg_ready <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_cfg_ready <= ~w_accept;
            r_cfg_err   <= w_wr_bad;
        end
    end

    // ------------------------------------------------------------------
    // Channels: increment registers live here and the datapath lives in
    // nco_chan. The new increment is used from the next accumulator
    // update onward. A phase clear zeroes the accumulator at the same
    // edge that accepts the write.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [ACC_W-1:0] r_inc;
        logic             w_sel;

        assign w_sel = w_wr_ok && (cfg_ch == CH_IDX_W'(i));

        always_ff @(posedge refclk) begin
            if (rst) begin
                r_inc <= '0;
            end else if (w_sel) begin
                r_inc <= cfg_inc;
            end
        end

        assign w_inc_nz[i] = |r_inc;

        nco_chan #(
            .ACC_W (ACC_W)
        ) u_chan (
            .clk   (refclk),
            .rst   (rst),
            .i_inc (r_inc),
            .i_clr (w_sel & cfg_phase_clr),
            .o_ce  (ce[i]),
            .o_sq  (sq[i])
        );
    end

    assign w_all_nz = &w_inc_nz;

    // ------------------------------------------------------------------
    // Lock counter. Any write to a real channel restarts settling, even
    // if the value written is unchanged. A parked channel (inc == 0)
    // holds the count at zero. A write to a bad channel index leaves the
    // count alone.
    // ------------------------------------------------------------------
    always_ff @(posedge refclk) begin
        if (rst) begin
            r_lock_cnt <= '0;
        end else if (w_wr_ok || !w_all_nz) begin
            r_lock_cnt <= '0;
        end else if (r_lock_cnt != c_lock_max) begin
            r_lock_cnt <= r_lock_cnt + c_lcw'(1);
        end
    end

    assign cfg_ready = r_cfg_ready;
    assign cfg_err   = r_cfg_err;
    assign locked    = (r_lock_cnt == c_lock_max);

endmodule : clken_nco
`default_nettype wire
